// File: rtl/col_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : col_pkg                                                        |
// | Purpose   : Shared widths and field positions of the column hit word.      |
// |             Hit word = {col_data[26:0], addr_config}; TOT and TOA field    |
// |             positions are given relative to the full 28-bit word.          |
// | Ports     : none (package)                                                 |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package col_pkg;

  localparam int COL_WORD_W  = 28;
  localparam int COL_DATA_W  = 27;
  localparam int COL_TOT_LSB = 5;
  localparam int COL_TOT_MSB = 12;
  localparam int COL_TOA_LSB = 18;
  localparam int COL_TOA_MSB = 26;

  typedef logic [COL_WORD_W-1:0] col_word_t;

endpackage : col_pkg
`default_nettype wire

// File: rtl/col_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : col_fifo_if                                                    |
// | Purpose   : Write/back-pressure and read-port signals of the column hit    |
// |             FIFO.                                                          |
// | Modports  : slave  - the FIFO (inputs: col_fifo_data, wr_fifo, rd_en)      |
// |             master - upstream column logic plus periphery readout          |
// | Signals   : col_fifo_data[27:0], wr_fifo, fifo_full, rd_en, rd_data[27:0], |
// |             rd_valid, fifo_empty, word_cnt[AW:0],                          |
// |             hit_cnt[15:0] (only with COL_FIFO_HIT_CNT_EN)                  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface col_fifo_if
  import col_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  col_word_t   col_fifo_data;
  logic        wr_fifo;
  logic        fifo_full;
  logic        rd_en;
  col_word_t   rd_data;
  logic        rd_valid;
  logic        fifo_empty;
  logic [AW:0] word_cnt;
`ifdef COL_FIFO_HIT_CNT_EN
  logic [15:0] hit_cnt;
`endif

  modport slave (
`ifdef COL_FIFO_HIT_CNT_EN
    output hit_cnt,
`endif
    input  col_fifo_data, wr_fifo, rd_en,
    output fifo_full, rd_data, rd_valid, fifo_empty, word_cnt
  );

  modport master (
`ifdef COL_FIFO_HIT_CNT_EN
    input  hit_cnt,
`endif
    output col_fifo_data, wr_fifo, rd_en,
    input  fifo_full, rd_data, rd_valid, fifo_empty, word_cnt
  );

endinterface : col_fifo_if
`default_nettype wire

// File: rtl/col_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : col_fifo_mem                                                   |
// | Purpose   : DEPTH x 28 register array, one synchronous write port and one  |
// |             asynchronous read port. Not reset; the owner's pointers decide |
// |             which entries are meaningful.                                  |
// | Ports     : clk_40MHz - clock                                              |
// |             wr_en/wr_addr/wr_data - write port                             |
// |             rd_addr/rd_data      - read port (combinational)               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module col_fifo_mem
  import col_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk_40MHz,
  input  wire logic          wr_en,
  input  wire logic [AW-1:0] wr_addr,
  input  wire col_word_t     wr_data,
  input  wire logic [AW-1:0] rd_addr,
  output col_word_t          rd_data
);

  col_word_t mem [DEPTH];

  always_ff @(posedge clk_40MHz) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The top level registers this value into rd_data, so the output stays
  // registered even though this port is combinational.
  assign rd_data = mem[rd_addr];

endmodule : col_fifo_mem
`default_nettype wire

// File: rtl/col_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : col_fifo                                                       |
// | Purpose   : Per-column hit buffer behind the end-of-column interface.      |
// |             Stores non-zero hit words that differ from the previously      |
// |             accepted word (upstream holds its word while wr_fifo is high), |
// |             and serves them to the readout through a registered read port. |
// | Ports     : clk_40MHz   - clock, rising edge                               |
// |             rst_n_pixel - asynchronous active-low reset                    |
// |             bus         - col_fifo_if.slave (data, strobes, flags, count)  |
// | Options   : `define COL_FIFO_HIT_CNT_EN adds a saturating 16-bit count of  |
// |             accepted words on bus.hit_cnt.                                 |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module col_fifo
  import col_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic   clk_40MHz,
  input  wire logic   rst_n_pixel,
  col_fifo_if.slave   bus
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  col_word_t     last_word;
  col_word_t     mem_rd_data;
  logic          wr_accept;
  logic          rd_pop;
  logic [AW:0]   cnt_nxt;

  // Flags are registered, so both decisions use the pre-edge view: a full
  // FIFO refuses the write even when a pop happens at the same edge, and an
  // empty FIFO ignores a read even when a write happens at the same edge.
  assign wr_accept = bus.wr_fifo && !bus.fifo_full
                     && (bus.col_fifo_data != '0)
                     && (bus.col_fifo_data != last_word);
  assign rd_pop    = bus.rd_en && !bus.fifo_empty;

  always_comb begin
    cnt_nxt = bus.word_cnt;
    case ({wr_accept, rd_pop})
      2'b10:   cnt_nxt = bus.word_cnt + CNT_ONE;
      2'b01:   cnt_nxt = bus.word_cnt - CNT_ONE;
      default: cnt_nxt = bus.word_cnt;
    endcase
  end

  always_ff @(posedge clk_40MHz or negedge rst_n_pixel) begin
    if (!rst_n_pixel) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      last_word      <= '0;
      bus.word_cnt   <= '0;
      bus.fifo_full  <= 1'b0;
      bus.fifo_empty <= 1'b1;
      bus.rd_data    <= '0;
      bus.rd_valid   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        last_word <= bus.col_fifo_data;
      end
      if (rd_pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        bus.rd_data <= mem_rd_data;
      end
      bus.rd_valid   <= rd_pop;
      bus.word_cnt   <= cnt_nxt;
      bus.fifo_full  <= (cnt_nxt == FULL_CNT);
      bus.fifo_empty <= (cnt_nxt == '0);
    end
  end

  col_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_40MHz (clk_40MHz),
    .wr_en     (wr_accept),
    .wr_addr   (wr_ptr),
    .wr_data   (bus.col_fifo_data),
    .rd_addr   (rd_ptr),
    .rd_data   (mem_rd_data)
  );

`ifdef COL_FIFO_HIT_CNT_EN
  always_ff @(posedge clk_40MHz or negedge rst_n_pixel) begin
    if (!rst_n_pixel) begin
      bus.hit_cnt <= '0;
    end else if (wr_accept && (bus.hit_cnt != 16'hFFFF)) begin
      bus.hit_cnt <= bus.hit_cnt + 16'd1;
    end
  end
`endif

endmodule : col_fifo
`default_nettype wire

// File: tb/tb_col_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_col_fifo                                                    |
// | Purpose   : Self-checking bench for col_fifo (DEPTH = 8). A queue holds    |
// |             the words expected back from the read port; a stimulus table   |
// |             covers duplicate/zero suppression, hand sequences cover full,  |
// |             wrap, empty-read and asynchronous reset.                       |
// | Options   : COL_FIFO_HIT_CNT_EN enables the hit counter checks.            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_col_fifo;
  import col_pkg::*;

  localparam int DEPTH = 8;

  logic clk_40MHz = 1'b0;
  logic rst_n_pixel = 1'b0;
  logic wr_req = 1'b0;

  int checks = 0;
  int errors = 0;

  col_fifo_if #(.DEPTH(DEPTH)) bus ();

  col_fifo #(.DEPTH(DEPTH)) dut (
    .clk_40MHz   (clk_40MHz),
    .rst_n_pixel (rst_n_pixel),
    .bus         (bus)
  );

  always #12 clk_40MHz = ~clk_40MHz;

  // Upstream behaviour: the strobe is high whenever the FIFO is not full.
  assign bus.wr_fifo = wr_req && !bus.fifo_full;

  // Reference model state
  col_word_t sb[$];
  col_word_t m_last;
  col_word_t exp_rdata;
  int        m_cnt;
  int        m_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_last    = '0;
    exp_rdata = '0;
    m_cnt     = 0;
    m_hit     = 0;
  endtask

  // One clock: drive inputs, advance at the edge, compare all outputs.
  task automatic cycle(input logic wr, input col_word_t d, input logic rd);
    logic acc, pp;
    wr_req            = wr;
    bus.col_fifo_data = d;
    bus.rd_en         = rd;
    acc = wr && (m_cnt != DEPTH) && (d != '0) && (d != m_last);
    pp  = rd && (m_cnt != 0);
    @(posedge clk_40MHz);
    #1;
    if (pp) exp_rdata = sb.pop_front();
    if (acc) begin
      sb.push_back(d);
      m_last = d;
      if (m_hit != 32'hFFFF) m_hit++;
    end
    m_cnt = m_cnt + int'(acc) - int'(pp);
    check("rd_valid",   32'(bus.rd_valid),   32'(pp));
    check("rd_data",    32'(bus.rd_data),    32'(exp_rdata));
    check("word_cnt",   32'(bus.word_cnt),   32'(m_cnt));
    check("fifo_full",  32'(bus.fifo_full),  32'(m_cnt == DEPTH));
    check("fifo_empty", 32'(bus.fifo_empty), 32'(m_cnt == 0));
`ifdef COL_FIFO_HIT_CNT_EN
    check("hit_cnt",    32'(bus.hit_cnt),    32'(m_hit));
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, '0, 1'b1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic       wr;
    col_word_t  data;
    logic       rd;
    logic [3:0] cnt;
    logic       valid;
    col_word_t  rdata;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Hand-derived expectations for duplicate and zero suppression.
    for (int i = 0; i < 5; i++)  tbl[i] = '{1'b1, 28'h00010A3, 1'b0, 4'd1, 1'b0, 28'h0};
    for (int i = 5; i < 10; i++) tbl[i] = '{1'b1, 28'h00020A3, 1'b0, 4'd2, 1'b0, 28'h0};
    tbl[10] = '{1'b1, 28'h0000000, 1'b0, 4'd2, 1'b0, 28'h0};
    tbl[11] = '{1'b1, 28'h0000000, 1'b1, 4'd1, 1'b1, 28'h00010A3};
    tbl[12] = '{1'b1, 28'h0000000, 1'b1, 4'd0, 1'b1, 28'h00020A3};
    tbl[13] = '{1'b0, 28'h0000000, 1'b1, 4'd0, 1'b0, 28'h00020A3};
    // Differs from the last accepted word, so it is stored again.
    tbl[14] = '{1'b1, 28'h00010A3, 1'b0, 4'd1, 1'b0, 28'h00020A3};
    // Held word is now a duplicate; only the pop happens.
    tbl[15] = '{1'b1, 28'h00010A3, 1'b1, 4'd0, 1'b1, 28'h00010A3};

    bus.col_fifo_data = '0;
    bus.rd_en         = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk_40MHz);
    #1;
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_full",  32'(bus.fifo_full),  32'd0);
    check("rst_cnt",   32'(bus.word_cnt),   32'd0);
    check("rst_valid", 32'(bus.rd_valid),   32'd0);
    check("rst_rdata", 32'(bus.rd_data),    32'd0);
    #4 rst_n_pixel = 1'b1;

    // Duplicate and zero suppression table
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].wr, tbl[i].data, tbl[i].rd);
      check($sformatf("tbl%0d_cnt", i),   32'(bus.word_cnt), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_valid", i), 32'(bus.rd_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_rdata", i), 32'(bus.rd_data),  32'(tbl[i].rdata));
    end

    // Fill to full, then hold a 9th word across the full period
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 28'(28'h0100000 + i), 1'b0);
    check("full_set", 32'(bus.fifo_full), 32'd1);
    check("wr_drop",  32'(bus.wr_fifo),   32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 28'h0ABCDE1, 1'b0);
    cycle(1'b1, 28'h0ABCDE1, 1'b1);
    check("full_pop_cnt", 32'(bus.word_cnt), 32'd7);
    cycle(1'b1, 28'h0ABCDE1, 1'b0);
    check("ninth_in_cnt", 32'(bus.word_cnt), 32'd8);
    cycle(1'b1, 28'h0ABCDE1, 1'b0);
    cycle(1'b1, 28'h0ABCDE1, 1'b0);
    wr_req = 1'b0;
    drain();

    // Pointer wrap with simultaneous read/write at constant occupancy
    for (int i = 0; i < 3; i++) cycle(1'b1, 28'(28'h0200000 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 28'(28'h0300000 + i), 1'b1);
      check("wrap_cnt_const", 32'(bus.word_cnt), 32'd3);
    end
    drain();

    // Empty read, then a write alongside a read while empty
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 28'h0777777, 1'b1);
    check("empty_wr_rd_valid", 32'(bus.rd_valid), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check("empty_wr_readback", 32'(bus.rd_data), 32'h0777777);

    // Asynchronous reset with 3 words stored, asserted mid-cycle
    for (int i = 0; i < 3; i++) cycle(1'b1, 28'(28'h0400000 + i), 1'b0);
    wr_req = 1'b0;
    #5 rst_n_pixel = 1'b0;
    #1;
    check("arst_empty", 32'(bus.fifo_empty), 32'd1);
    check("arst_full",  32'(bus.fifo_full),  32'd0);
    check("arst_cnt",   32'(bus.word_cnt),   32'd0);
    check("arst_valid", 32'(bus.rd_valid),   32'd0);
    check("arst_rdata", 32'(bus.rd_data),    32'd0);
    @(negedge clk_40MHz);
    rst_n_pixel = 1'b1;
    model_reset();
    // Same word as the last one before reset: accepted because last_word cleared.
    cycle(1'b1, 28'h0400002, 1'b0);
    check("arst_last_cleared", 32'(bus.word_cnt), 32'd1);
    wr_req = 1'b0;
    drain();

`ifdef COL_FIFO_HIT_CNT_EN
    // Saturation of the hit counter with interleaved pops
    for (int i = 0; i < 70000; i++) cycle(1'b1, 28'(i + 1), (i != 0));
    cycle(1'b1, 28'(70000), 1'b1);
    check("hit_sat", 32'(bus.hit_cnt), 32'hFFFF);
    wr_req = 1'b0;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_col_fifo
`default_nettype wire

// File: doc/col_fifo.md
# col_fifo

Per-column hit buffer that sits directly downstream of the column end-of-column interface. It takes 28-bit hit words `{col_data, addr_config}` plus the write strobe and returns `fifo_full` as back-pressure. The write strobe stays high whenever the FIFO is not full, so the block drops repeated presentations of the same held word. It buffers accepted words for the periphery readout, which drains them with a registered read port.

## Interface

Parameters:
- `DEPTH`, 8: number of words; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width.

Ports:
- `clk_40MHz` in 1: system clock, rising edge.
- `rst_n_pixel` in 1: reset, asynchronous, active-low.
- `col_fifo_data` in 28: hit word. Bits [27:1] are column data; bit [0] is the column address.
- `wr_fifo` in 1: write request from upstream; high whenever `fifo_full` is low.
- `fifo_full` out 1: back-pressure to upstream.
- `rd_en` in 1: read request from readout.
- `rd_data` out 28: read word, registered.
- `rd_valid` out 1: `rd_data` is valid this cycle (one-cycle pulse per pop).
- `fifo_empty` out 1: no stored words.
- `word_cnt` out AW+1: current occupancy, 0..DEPTH.
- `hit_cnt` out 16: accepted-word counter; present only with `COL_FIFO_HIT_CNT_EN`.

## Operation

**Accept rule.** A write is accepted at an edge only when all of these hold:
- `wr_fifo` is 1.
- `fifo_full` is 0, sampled before that edge.
- `col_fifo_data` is not 28'd0.
- `col_fifo_data` is not equal to `last_word`.

On an accepted write:
- the word is stored at `wr_ptr`;
- `wr_ptr` increments, wrapping modulo DEPTH;
- `last_word` is loaded with the word.

`last_word` resets to 0. A zero word is never stored. Two genuinely identical consecutive hits collapse to one; this is accepted behaviour, because TOA differs between real hits.

**Pop rule.** A pop occurs when `rd_en` is 1 and `fifo_empty` is 0, sampled before the edge. On a pop:
- `rd_data` loads `mem[rd_ptr]`;
- `rd_ptr` increments, wrapping;
- `rd_valid` goes to 1 for exactly one cycle.

When no pop occurs, `rd_data` holds its last value and `rd_valid` is 0. `rd_en` while empty is ignored.

**Occupancy.** `word_cnt` is incremented on an accepted write and decremented on a pop. A simultaneous write and pop leaves it unchanged.

**Flags.**
- `fifo_full` = (`word_cnt` == DEPTH).
- `fifo_empty` = (`word_cnt` == 0).
- Both are registered, so they reflect the count after the edge.

**Boundary rules.**
- Full plus a pop in the same cycle: no write is accepted that cycle, because full was sampled high. The write is accepted on the next edge, since upstream holds the word.
- Empty plus a write in the same cycle: the pop is ignored. The word is readable from the following cycle.
- A word held by upstream while full is written exactly once after full drops. No word is lost.
- Reset mid-operation: contents are discarded, and pointers, counts and `last_word` are cleared immediately.

**Reset values.**
- `fifo_full` = 0
- `fifo_empty` = 1
- `word_cnt` = 0
- `rd_data` = 0
- `rd_valid` = 0
- `hit_cnt` = 0

The memory array is not reset.

## Timing

- Write-to-readable latency: a word accepted at edge N gives `fifo_empty` = 0 after N. A pop at N+1 gives `rd_data`/`rd_valid` valid after N+1.
- Read latency: 1 cycle from a sampled `rd_en` to `rd_valid`.
- `fifo_full` rises in the cycle after the edge that fills the last slot. Upstream sees `wr_fifo` drop combinationally within that same cycle.
- Sustained throughput: one write and one pop per cycle, both at the same time.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

`COL_FIFO_HIT_CNT_EN`:
- **Defined:** `hit_cnt` port and a 16-bit counter exist. The counter increments on every accepted write and saturates at 16'hFFFF. It is cleared only by `rst_n_pixel`.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure

Package `col_pkg`:
- `COL_WORD_W` = 28
- `COL_DATA_W` = 27
- `COL_TOT_LSB` = 5, `COL_TOT_MSB` = 12
- `COL_TOA_LSB` = 18, `COL_TOA_MSB` = 26
- typedef `col_word_t` (logic [27:0])

Sub-module `col_fifo_mem`: DEPTH×28 register array with one synchronous write port and one read port, no reset. The top level holds the pointers, counts, flags, duplicate filter and optional counter.

## Test plan

- **Reset.** Hold `rst_n_pixel` = 0 → `fifo_empty` = 1, `fifo_full` = 0, `word_cnt` = 0, `rd_valid` = 0. Assert reset mid-stream with 3 words stored → all cleared in the same cycle.
- **Duplicate suppression.** Keep `wr_fifo` = 1 and `col_fifo_data` = 28'h0001_0A3 for 5 cycles, then 28'h0002_0A3 for 5 cycles → `word_cnt` = 2. Popping twice returns 28'h0001_0A3 then 28'h0002_0A3. Also drive 28'h0 → nothing stored.
- **Fill to full, DEPTH = 8.** Write 8 distinct words → `fifo_full` = 1 and `wr_fifo` drops. Present a 9th word held for 4 cycles, then pop once → the 9th word is stored exactly once and `word_cnt` returns to 8.
- **Pointer wrap.** Push and pop 20 distinct words with simultaneous read/write → order preserved, `word_cnt` stays constant, no spurious `rd_valid`.
- **Empty read.** With `fifo_empty` = 1, assert `rd_en` for 3 cycles → `rd_valid` = 0 and `rd_data` unchanged. A write in the same cycle as `rd_en` is readable on the next pop.
- **Hit counter (macro on).** Make 70000 distinct accepted writes with interleaved pops → `hit_cnt` = 16'hFFFF, saturated. Duplicates do not increment it.
